// File: rtl/mv_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mv_tile_ctrl
// Purpose  : Job sequencer for the matrix-vector accelerator. Latches a
//            runtime job (accumulation depth, tile count, output base),
//            validates it, then for each row tile clears the PE array,
//            streams K operand addresses, waits for the PE pipeline to
//            settle, snapshots the parallel result and drains it to the
//            outcome SRAM WR_LANES elements per cycle.
// Ports    : clk/srstn            clock, asynchronous active-low reset
//            start, cfg_*         job request and configuration (IDLE only)
//            abort                cancel a running job
//            busy/done/error/err_code   job handshake and status
//            sram_w_raddr/sram_v_raddr  weight / vector read addresses
//            alu_start/alu_clear/cycle_num/tile_idx   PE core control
//            result_in            PE parallel result
//            sram_o_we/sram_o_waddr/sram_o_wdata      outcome SRAM write
// Revision : 1.0 - initial release
// ============================================================================
module mv_tile_ctrl #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 32,
    parameter int K_MAX      = 64,
    parameter int TILE_MAX   = 4,
    parameter int WR_LANES   = 4,
    parameter int ACC_LAT    = 2,
    parameter int O_DEPTH    = 64
) (
    input  logic                                clk,
    input  logic                                srstn,
    input  logic                                start,
    input  logic [$clog2(K_MAX+1)-1:0]          cfg_k_len,
    input  logic [$clog2(TILE_MAX+1)-1:0]       cfg_tiles,
    input  logic [$clog2(O_DEPTH)-1:0]          cfg_out_base,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [1:0]                          err_code,
    output logic [$clog2(K_MAX*TILE_MAX)-1:0]   sram_w_raddr,
    output logic [$clog2(K_MAX)-1:0]            sram_v_raddr,
    output logic                                alu_start,
    output logic                                alu_clear,
    output logic [8:0]                          cycle_num,
    output logic [$clog2(TILE_MAX)-1:0]         tile_idx,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]    result_in,
    output logic                                sram_o_we,
    output logic [$clog2(O_DEPTH)-1:0]          sram_o_waddr,
    output logic [WR_LANES*DATA_WIDTH-1:0]      sram_o_wdata
);

    localparam int c_KW      = $clog2(K_MAX + 1);
    localparam int c_TW      = $clog2(TILE_MAX + 1);
    localparam int c_TIW     = $clog2(TILE_MAX);
    localparam int c_OW      = $clog2(O_DEPTH);
    localparam int c_WAW     = $clog2(K_MAX * TILE_MAX);
    localparam int c_VAW     = $clog2(K_MAX);
    localparam int c_G       = ARRAY_SIZE / WR_LANES;
    localparam int c_WW      = WR_LANES * DATA_WIDTH;
    localparam int c_CNT_MAX = (ACC_LAT > c_G) ? ACC_LAT : c_G;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_CHECK = 3'd1;
    localparam logic [2:0] c_S_LOAD  = 3'd2;
    localparam logic [2:0] c_S_ACCUM = 3'd3;
    localparam logic [2:0] c_S_FLUSH = 3'd4;
    localparam logic [2:0] c_S_WRITE = 3'd5;
    localparam logic [2:0] c_S_DONE  = 3'd6;

    logic [2:0]                         r_state;
    logic [2:0]                         w_state_next;
    logic [c_KW-1:0]                    r_k_len;
    logic [c_TW-1:0]                    r_tiles;
    logic [c_OW-1:0]                    r_base;
    logic [c_TIW-1:0]                   r_tile;
    logic [c_KW-1:0]                    r_k;
    logic [c_CW-1:0]                    r_cnt;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0]   r_snap;
    logic [1:0]                         r_err_code;

    logic w_bad_k;
    logic w_bad_t;
    logic w_active;
    logic w_k_last;
    logic w_flush_last;
    logic w_grp_last;
    logic w_tile_last;
    logic [c_WAW-1:0] w_wbase;

    assign w_bad_k      = (r_k_len == '0) || (r_k_len > c_KW'(K_MAX));
    assign w_bad_t      = (r_tiles == '0) || (r_tiles > c_TW'(TILE_MAX));
    assign w_active     = (r_state != c_S_IDLE) && (r_state != c_S_DONE);
    assign w_k_last     = (r_k == r_k_len - c_KW'(1));
    assign w_flush_last = (r_cnt == c_CW'(ACC_LAT - 1));
    assign w_grp_last   = (r_cnt == c_CW'(c_G - 1));
    assign w_tile_last  = ((c_TW'(r_tile) + c_TW'(1)) >= r_tiles);
    assign w_wbase      = c_WAW'(int'(r_tile) * K_MAX);

    // Next-state logic; abort pre-empts every working state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_next = c_S_CHECK;
            c_S_CHECK: begin
                if (abort || w_bad_k || w_bad_t) w_state_next = c_S_DONE;
                else                             w_state_next = c_S_LOAD;
            end
            c_S_LOAD:  w_state_next = abort ? c_S_DONE : c_S_ACCUM;
            c_S_ACCUM: begin
                if (abort)         w_state_next = c_S_DONE;
                else if (w_k_last) w_state_next = c_S_FLUSH;
            end
            c_S_FLUSH: begin
                if (abort)             w_state_next = c_S_DONE;
                else if (w_flush_last) w_state_next = c_S_WRITE;
            end
            c_S_WRITE: begin
                if (abort)           w_state_next = c_S_DONE;
                else if (w_grp_last) w_state_next = w_tile_last ? c_S_DONE : c_S_LOAD;
            end
            c_S_DONE:  w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state    <= c_S_IDLE;
            r_k_len    <= '0;
            r_tiles    <= '0;
            r_base     <= '0;
            r_tile     <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_snap     <= '0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_k_len    <= cfg_k_len;
                        r_tiles    <= cfg_tiles;
                        r_base     <= cfg_out_base;
                        r_err_code <= 2'b00;
                    end
                end
                c_S_CHECK: begin
                    r_tile <= '0;
                    if (w_bad_k)      r_err_code <= 2'b01;
                    else if (w_bad_t) r_err_code <= 2'b10;
                end
                c_S_LOAD: begin
                    r_k   <= '0;
                    r_cnt <= '0;
                end
                c_S_ACCUM: r_k <= r_k + c_KW'(1);
                c_S_FLUSH: begin
                    if (w_flush_last) begin
                        r_cnt  <= '0;
                        r_snap <= result_in;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_S_WRITE: begin
                    if (w_grp_last) begin
                        r_cnt <= '0;
                        if (!w_tile_last) r_tile <= r_tile + c_TIW'(1);
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: ;
            endcase
            // Abort code overrides any config-check result decided this cycle.
            if (abort && w_active) r_err_code <= 2'b11;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy         = w_active;
        done         = (r_state == c_S_DONE);
        error        = (r_err_code != 2'b00);
        err_code     = r_err_code;
        alu_clear    = (r_state == c_S_LOAD);
        alu_start    = (r_state == c_S_ACCUM) || (r_state == c_S_FLUSH);
        sram_o_we    = (r_state == c_S_WRITE);
        cycle_num    = 9'd0;
        sram_w_raddr = '0;
        sram_v_raddr = '0;
        tile_idx     = '0;
        sram_o_waddr = '0;
        sram_o_wdata = '0;
        if ((r_state >= c_S_LOAD) && (r_state <= c_S_WRITE)) tile_idx = r_tile;
        case (r_state)
            c_S_LOAD:  sram_w_raddr = w_wbase;
            c_S_ACCUM: begin
                // Addresses run one ahead of cycle_num to hide SRAM latency.
                cycle_num    = 9'(r_k);
                sram_w_raddr = w_wbase + c_WAW'(r_k) + c_WAW'(1);
                sram_v_raddr = c_VAW'(r_k) + c_VAW'(1);
            end
            c_S_FLUSH: cycle_num = 9'(r_k_len);
            c_S_WRITE: begin
                sram_o_waddr = c_OW'(int'(r_base) + int'(r_tile) * c_G + int'(r_cnt));
                sram_o_wdata = r_snap[r_cnt*c_WW +: c_WW];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
